// File: rtl/iob_ethmac_pkg.sv
// Shared types and width helpers for the ethmac IOb arbiter slice.
package iob_ethmac_pkg;

    // Arbiter FSM encoding
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Width of an index/counter able to hold values 0..v-1, never below one bit
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Combinational round-robin priority encoder: first set request at or after ptr, with wrap.
module iob_rr_arbiter
    import iob_ethmac_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int unsigned cand;

    // Walk the requests starting at ptr; the first hit wins
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_vld && req[IDX_W'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/iob_ethmac_d_arbiter.sv
// Round-robin arbiter sharing one IOb memory port between N_MASTERS IOb masters.
// One whole transaction is granted at a time; a watchdog ends stalled transactions with an error.
module iob_ethmac_d_arbiter
    import iob_ethmac_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                              clk_i,
    input  logic                              arst_i,
    input  logic [N_MASTERS-1:0]              s_valid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]       s_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]       s_wdata_i,
    input  logic [N_MASTERS*(DATA_W/8)-1:0]   s_wstrb_i,
    output logic [DATA_W-1:0]                 s_rdata_o,
    output logic [N_MASTERS-1:0]              s_ready_o,
    output logic [N_MASTERS-1:0]              s_err_o,
    output logic                              m_valid_o,
    output logic [ADDR_W-1:0]                 m_addr_o,
    output logic [DATA_W-1:0]                 m_wdata_o,
    output logic [DATA_W/8-1:0]               m_wstrb_o,
    input  logic [DATA_W-1:0]                 m_rdata_i,
    input  logic                              m_ready_i,
    input  logic                              m_err_i
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = clog2_min1(N_MASTERS);
    localparam int unsigned WD_W   = clog2_min1(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             m_valid_q, m_valid_d;

    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             wd_expire;
    logic             txn_done;
    logic [IDX_W-1:0] owner_next;

    iob_rr_arbiter #(
        .N (N_MASTERS)
    ) u_rr_arbiter (
        .req     (s_valid_i),
        .ptr     (rr_ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Watchdog fires only when memory has not answered by the last allowed cycle
    assign wd_expire  = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST) && !m_ready_i;
    assign txn_done   = (state_q == ST_BUSY) && (m_ready_i || wd_expire);
    assign owner_next = (owner_q == IDX_W'(N_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);

    // State register; reset aborts any transaction without a response
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            wd_cnt_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            wd_cnt_q  <= wd_cnt_d;
            m_valid_q <= m_valid_d;
        end
    end

    // Next-state: grant in IDLE, count and complete in BUSY
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        wd_cnt_d  = wd_cnt_q;
        m_valid_d = m_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d   = ST_BUSY;
                    owner_d   = gnt_idx;
                    wd_cnt_d  = '0;
                    m_valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (txn_done) begin
                    state_d   = ST_IDLE;
                    rr_ptr_d  = owner_next;
                    wd_cnt_d  = '0;
                    m_valid_d = 1'b0;
                end else if (wd_cnt_q != WD_MAX) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
            end
        endcase
    end

    // Outputs: owner's request muxed to memory, response routed back to owner
    always_comb begin
        s_ready_o = '0;
        s_err_o   = '0;
        s_rdata_o = '0;
        m_addr_o  = '0;
        m_wdata_o = '0;
        m_wstrb_o = '0;
        if (state_q == ST_BUSY) begin
            for (int unsigned i = 0; i < N_MASTERS; i++) begin
                if (owner_q == IDX_W'(i)) begin
                    m_addr_o  = s_addr_i[i*ADDR_W +: ADDR_W];
                    m_wdata_o = s_wdata_i[i*DATA_W +: DATA_W];
                    m_wstrb_o = s_wstrb_i[i*STRB_W +: STRB_W];
                    if (m_ready_i) begin
                        s_ready_o[i] = 1'b1;
                        s_err_o[i]   = m_err_i;
                    end else if (wd_expire) begin
                        s_ready_o[i] = 1'b1;
                        s_err_o[i]   = 1'b1;
                    end
                end
            end
            if (m_ready_i) begin
                s_rdata_o = m_rdata_i;
            end
        end
    end

    assign m_valid_o = m_valid_q;

endmodule

// File: tb/tb_iob_ethmac_d_arbiter.sv
// Self-checking bench for iob_ethmac_d_arbiter: transaction-level model with random traffic.
module tb_iob_ethmac_d_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic              clk;
    logic              arst_i;
    logic [N-1:0]      s_valid_i;
    logic [N*AW-1:0]   s_addr_i;
    logic [N*DW-1:0]   s_wdata_i;
    logic [N*SW-1:0]   s_wstrb_i;
    logic [DW-1:0]     s_rdata_o;
    logic [N-1:0]      s_ready_o;
    logic [N-1:0]      s_err_o;
    logic              m_valid_o;
    logic [AW-1:0]     m_addr_o;
    logic [DW-1:0]     m_wdata_o;
    logic [SW-1:0]     m_wstrb_o;
    logic [DW-1:0]     m_rdata_i;
    logic              m_ready_i;
    logic              m_err_i;

    iob_ethmac_d_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i     (clk),
        .arst_i    (arst_i),
        .s_valid_i (s_valid_i),
        .s_addr_i  (s_addr_i),
        .s_wdata_i (s_wdata_i),
        .s_wstrb_i (s_wstrb_i),
        .s_rdata_o (s_rdata_o),
        .s_ready_o (s_ready_o),
        .s_err_o   (s_err_o),
        .m_valid_o (m_valid_o),
        .m_addr_o  (m_addr_o),
        .m_wdata_o (m_wdata_o),
        .m_wstrb_o (m_wstrb_o),
        .m_rdata_i (m_rdata_i),
        .m_ready_i (m_ready_i),
        .m_err_i   (m_err_i)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int errors    = 0;

    // Master-side view and reference state
    logic          req      [N];
    logic [AW-1:0] pay_addr [N];
    logic [DW-1:0] pay_wdata[N];
    logic [SW-1:0] pay_wstrb[N];
    int            exp_ptr;
    int            last_w;
    int            obs_cnt  [N];
    int            obs_prev;
    int            obs_repeat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            s_valid_i[i]            = req[i];
            s_addr_i[i*AW +: AW]    = pay_addr[i];
            s_wdata_i[i*DW +: DW]   = pay_wdata[i];
            s_wstrb_i[i*SW +: SW]   = pay_wstrb[i];
        end
    endtask

    task automatic new_req(input int i);
        req[i]       = 1'b1;
        pay_addr[i]  = $urandom;
        pay_wdata[i] = $urandom;
        pay_wstrb[i] = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
    endtask

    // Expected winner: first requester at or after the master following the last one served
    function automatic int exp_winner();
        for (int k = 0; k < N; k++) begin
            if (req[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
        end
        return -1;
    endfunction

    // One granted transaction; d = idle memory cycles before ready
    task automatic run_txn(input int d, input logic err, input logic drop, input logic [DW-1:0] rd);
        int w;
        int kr;
        logic normal;
        apply();
        @(negedge clk);
        check("arb_cycle_mvalid", 64'(m_valid_o), 64'd0);
        check("arb_cycle_addr",   64'(m_addr_o),  64'd0);
        check("arb_cycle_ready",  64'(s_ready_o), 64'd0);
        w      = exp_winner();
        normal = (d + 1 <= TO);
        kr     = normal ? d + 1 : TO;
        if (w < 0) begin
            check("no_requester", 64'd1, 64'd0);
            return;
        end
        for (int k = 1; k <= kr; k++) begin
            @(posedge clk); #1;
            m_ready_i = (k == d + 1);
            m_rdata_i = (k == d + 1) ? rd : DW'($urandom);
            m_err_i   = (k == d + 1) ? err : 1'($urandom);
            if (drop && k == 2) begin
                req[w] = 1'b0;
                apply();
            end
            @(negedge clk);
            check("busy_mvalid", 64'(m_valid_o), 64'd1);
            check("busy_addr",   64'(m_addr_o),  64'(pay_addr[w]));
            check("busy_wdata",  64'(m_wdata_o), 64'(pay_wdata[w]));
            check("busy_wstrb",  64'(m_wstrb_o), 64'(pay_wstrb[w]));
            if (k < kr) begin
                check("busy_no_resp", 64'(s_ready_o), 64'd0);
            end else begin
                check("resp_ready", 64'(s_ready_o), 64'(1 << w));
                if (normal) begin
                    check("resp_err",   64'(s_err_o),   err ? 64'(1 << w) : 64'd0);
                    check("resp_rdata", 64'(s_rdata_o), 64'(rd));
                end else begin
                    check("wd_err",   64'(s_err_o),   64'(1 << w));
                    check("wd_rdata", 64'(s_rdata_o), 64'd0);
                end
                for (int i = 0; i < N; i++) begin
                    if (s_ready_o[i]) begin
                        obs_cnt[i]++;
                        if (i == obs_prev) obs_repeat++;
                        obs_prev = i;
                    end
                end
            end
        end
        exp_ptr = (w + 1) % N;
        last_w  = w;
        @(posedge clk); #1;
        m_ready_i = 1'b0;
        m_err_i   = 1'b0;
    endtask

    // Memory completion with nobody granted must be ignored
    task automatic idle_ready_pulse();
        apply();
        m_ready_i = 1'b1;
        m_err_i   = 1'b1;
        m_rdata_i = $urandom;
        @(negedge clk);
        check("idle_ready_ignored", 64'(s_ready_o), 64'd0);
        check("idle_rdata_zero",    64'(s_rdata_o), 64'd0);
        check("idle_mvalid",        64'(m_valid_o), 64'd0);
        @(posedge clk); #1;
        m_ready_i = 1'b0;
        m_err_i   = 1'b0;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) req[i] = 1'b0;
    endtask

    initial begin
        clk       = 1'b0;
        arst_i    = 1'b1;
        m_ready_i = 1'b0;
        m_err_i   = 1'b0;
        m_rdata_i = '0;
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b0; pay_addr[i] = '0; pay_wdata[i] = '0; pay_wstrb[i] = '0;
            obs_cnt[i] = 0;
        end
        exp_ptr = 0; last_w = 0; obs_prev = -1; obs_repeat = 0;
        apply();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mvalid", 64'(m_valid_o), 64'd0);
        check("rst_ready",  64'(s_ready_o), 64'd0);
        check("rst_err",    64'(s_err_o),   64'd0);
        check("rst_rdata",  64'(s_rdata_o), 64'd0);
        check("rst_addr",   64'(m_addr_o),  64'd0);
        @(posedge clk); #1;
        arst_i = 1'b0;

        // Single read from m0, ready after 3 busy cycles
        new_req(0);
        pay_addr[0] = 32'h100; pay_wstrb[0] = '0;
        run_txn(2, 1'b0, 1'b0, 32'hDEADBEEF);
        clear_reqs();

        // Write from m1
        req[1] = 1'b1; pay_addr[1] = 32'h2000; pay_wdata[1] = 32'h12345678; pay_wstrb[1] = 4'hF;
        run_txn(0, 1'b0, 1'b0, 32'h0);
        clear_reqs();

        // Contention: both continuously requesting, 8 completions
        for (int i = 0; i < N; i++) obs_cnt[i] = 0;
        obs_prev = -1; obs_repeat = 0;
        new_req(0); new_req(1);
        for (int t = 0; t < 8; t++) begin
            run_txn(0, 1'b0, 1'b0, $urandom);
            new_req(last_w);
        end
        check("fair_cnt_m0", 64'(obs_cnt[0]), 64'd4);
        check("fair_cnt_m1", 64'(obs_cnt[1]), 64'd4);
        check("fair_no_repeat", 64'(obs_repeat), 64'd0);
        clear_reqs();

        // Timeout, error pass-through, ready coincident with watchdog expiry
        new_req(0); run_txn(20, 1'b0, 1'b0, $urandom); clear_reqs();
        new_req(1); run_txn(1,  1'b1, 1'b0, $urandom); clear_reqs();
        new_req(0); run_txn(TO - 1, 1'b0, 1'b0, $urandom); clear_reqs();

        // Reset mid-transaction: move pointer to 1, then abort a grant to m1
        apply();
        idle_ready_pulse();
        new_req(0); run_txn(0, 1'b0, 1'b0, $urandom);
        clear_reqs(); new_req(0); new_req(1); apply();
        @(negedge clk);
        check("pre_rst_arb_mvalid", 64'(m_valid_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_busy", 64'(m_valid_o), 64'd1);
        check("pre_rst_owner_addr", 64'(m_addr_o), 64'(pay_addr[1]));
        @(posedge clk); #1;
        arst_i = 1'b1; m_ready_i = 1'b1; m_rdata_i = $urandom;
        #1;
        check("rst_abort_mvalid", 64'(m_valid_o), 64'd0);
        check("rst_abort_ready",  64'(s_ready_o), 64'd0);
        @(posedge clk); #1;
        arst_i = 1'b0;
        clear_reqs(); apply();
        @(negedge clk);
        check("late_ready_ignored", 64'(s_ready_o), 64'd0);
        check("late_ready_mvalid",  64'(m_valid_o), 64'd0);
        @(posedge clk); #1;
        m_ready_i = 1'b0;
        exp_ptr = 0;
        new_req(1); run_txn(0, 1'b0, 1'b0, $urandom); clear_reqs();
        exp_ptr = 0;
        new_req(0); new_req(1);
        // Pointer advanced to 0 after m1, so m0 wins regardless; the earlier both-request after reset is below
        run_txn(0, 1'b0, 1'b0, $urandom); clear_reqs();

        // Pointer returns to 0 after reset even if it was 1 before
        new_req(0); run_txn(0, 1'b0, 1'b0, $urandom); clear_reqs(); apply();
        @(posedge clk); #1;
        arst_i = 1'b1;
        @(posedge clk); #1;
        arst_i = 1'b0;
        exp_ptr = 0;
        new_req(0); new_req(1);
        run_txn(0, 1'b0, 1'b0, $urandom);
        new_req(last_w);

        // Random traffic
        for (int t = 0; t < 200; t++) begin
            logic any;
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) new_req(i);
                any |= req[i];
            end
            if (!any) begin
                idle_ready_pulse();
                new_req($urandom_range(0, N - 1));
            end
            run_txn($urandom_range(0, 6), 1'($urandom), ($urandom_range(0, 7) == 0), $urandom);
            if ($urandom_range(0, 1) == 0) new_req(last_w);
            else req[last_w] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, errors);
        $finish;
    end

endmodule
